// File: rtl/code_mem_flash_programmer.sv
// code_mem_flash_programmer
// Copies a code image from code RAM into an on-chip flash sector over Avalon-MM.
// The sequence is: unprotect the sector, erase it, poll the erase, then for each word
// read it from RAM, write it to flash byte-swapped and poll the write, and finally
// re-protect every sector. The re-protect step runs even after an error.
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   start, num_words       1-cycle request and word count (latched on accept)
//   busy, done, error      status: busy span, completion pulse, sticky error
//   pram_re/addr/rdata     code RAM read port (data one cycle after pram_re)
//   avmm_csr_*             flash CSR slave (addr 0 status, addr 1 control)
//   avmm_data_*            flash data slave (single-word writes, waitrequest stall)
module code_mem_flash_programmer #(
    parameter int unsigned RAM_ADDR_WIDTH   = 12,
    parameter int unsigned FLASH_ADDR_WIDTH = 17,
    parameter int unsigned FLASH_BASE_WORD  = 0,
    parameter int unsigned SECTOR_ID        = 1,
    parameter int unsigned POLL_TIMEOUT     = 100000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [RAM_ADDR_WIDTH:0]     num_words,
    output logic                        busy,
    output logic                        done,
    output logic                        error,
    output logic                        pram_re,
    output logic [RAM_ADDR_WIDTH-1:0]   pram_addr,
    input  logic [31:0]                 pram_rdata,
    output logic                        avmm_csr_addr,
    output logic                        avmm_csr_read,
    output logic                        avmm_csr_write,
    output logic [31:0]                 avmm_csr_writedata,
    input  logic [31:0]                 avmm_csr_readdata,
    output logic [FLASH_ADDR_WIDTH-1:0] avmm_data_addr,
    output logic                        avmm_data_write,
    output logic [31:0]                 avmm_data_writedata,
    input  logic                        avmm_data_waitrequest,
    output logic [1:0]                  avmm_data_burstcount
);

    localparam int unsigned NW_W  = RAM_ADDR_WIDTH + 1;
    localparam int unsigned TMR_W = $clog2(POLL_TIMEOUT + 1);

    localparam logic [NW_W-1:0] MAX_WORDS  = {1'b1, {RAM_ADDR_WIDTH{1'b0}}};
    localparam logic [2:0]      ERASE_NONE = 3'd7;
    localparam logic [2:0]      ERASE_SEC  = 3'(SECTOR_ID);
    localparam logic [4:0]      PROT_ALL   = 5'h1F;
    localparam logic [4:0]      PROT_OPEN  = PROT_ALL & ~(5'(1) << (SECTOR_ID - 1));

    // Control register layout: [27:23] write-protect, [22:20] erase sector
    localparam logic [31:0] CTRL_UNPROT = {4'b0, PROT_OPEN, ERASE_NONE, 20'b0};
    localparam logic [31:0] CTRL_ERASE  = {4'b0, PROT_OPEN, ERASE_SEC,  20'b0};
    localparam logic [31:0] CTRL_PROT   = {4'b0, PROT_ALL,  ERASE_NONE, 20'b0};

    typedef enum logic [8:0] {
        S_IDLE   = 9'b000000001,
        S_UNPROT = 9'b000000010,
        S_ERASE  = 9'b000000100,
        S_EPOLL  = 9'b000001000,
        S_RAMRD  = 9'b000010000,
        S_WR     = 9'b000100000,
        S_WPOLL  = 9'b001000000,
        S_PROT   = 9'b010000000,
        S_DONE   = 9'b100000000
    } state_t;

    state_t                      r_state;
    logic                        r_busy;
    logic                        r_done;
    logic                        r_error;
    logic                        r_pram_re;
    logic [RAM_ADDR_WIDTH-1:0]   r_pram_addr;
    logic                        r_csr_addr;
    logic                        r_csr_read;
    logic                        r_csr_write;
    logic [31:0]                 r_csr_wdata;
    logic [FLASH_ADDR_WIDTH-1:0] r_data_addr;
    logic                        r_data_write;
    logic [31:0]                 r_data_wdata;
    logic [1:0]                  r_burstcount;
    logic [NW_W-1:0]             r_num_words;
    logic [RAM_ADDR_WIDTH-1:0]   r_index;
    logic [TMR_W-1:0]            r_timer;
    logic                        r_poll_phase;

    logic [NW_W-1:0]             w_nw_clamped;
    logic                        w_status_idle;
    logic                        w_timeout;
    logic                        w_last;
    logic [31:0]                 w_swapped;
    logic [FLASH_ADDR_WIDTH-1:0] w_flash_addr;
    logic                        w_unused;

    assign w_nw_clamped  = (num_words > MAX_WORDS) ? MAX_WORDS : num_words;
    assign w_status_idle = (avmm_csr_readdata[1:0] == 2'b00);
    assign w_timeout     = (r_timer == TMR_W'(POLL_TIMEOUT - 1));
    assign w_last        = ({1'b0, r_index} == (r_num_words - NW_W'(1)));
    assign w_swapped     = {pram_rdata[7:0], pram_rdata[15:8], pram_rdata[23:16], pram_rdata[31:24]};
    assign w_flash_addr  = FLASH_ADDR_WIDTH'(FLASH_BASE_WORD) + FLASH_ADDR_WIDTH'(r_index);
    assign w_unused      = ^{avmm_csr_readdata[31:5], avmm_csr_readdata[2]};

    // Sequencer; single-cycle strobes default low each cycle and are raised on state entry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_pram_re    <= 1'b0;
            r_pram_addr  <= '0;
            r_csr_addr   <= 1'b0;
            r_csr_read   <= 1'b0;
            r_csr_write  <= 1'b0;
            r_csr_wdata  <= '0;
            r_data_addr  <= '0;
            r_data_write <= 1'b0;
            r_data_wdata <= '0;
            r_burstcount <= 2'd1;
            r_num_words  <= '0;
            r_index      <= '0;
            r_timer      <= '0;
            r_poll_phase <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_pram_re   <= 1'b0;
            r_csr_read  <= 1'b0;
            r_csr_write <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_num_words <= w_nw_clamped;
                        r_error     <= 1'b0;
                        r_busy      <= 1'b1;
                        r_index     <= '0;
                        r_csr_write <= 1'b1;
                        r_csr_addr  <= 1'b1;
                        r_csr_wdata <= CTRL_UNPROT;
                        r_state     <= S_UNPROT;
                    end
                end

                S_UNPROT: begin
                    r_csr_write <= 1'b1;
                    r_csr_addr  <= 1'b1;
                    r_csr_wdata <= CTRL_ERASE;
                    r_state     <= S_ERASE;
                end

                S_ERASE: begin
                    r_csr_read   <= 1'b1;
                    r_csr_addr   <= 1'b0;
                    r_poll_phase <= 1'b0;
                    r_timer      <= '0;
                    r_state      <= S_EPOLL;
                end

                // Phase 0: read strobe is on the bus; phase 1: readdata is valid
                S_EPOLL: begin
                    r_timer <= r_timer + TMR_W'(1);
                    if (w_timeout) begin
                        r_error     <= 1'b1;
                        r_csr_write <= 1'b1;
                        r_csr_addr  <= 1'b1;
                        r_csr_wdata <= CTRL_PROT;
                        r_state     <= S_PROT;
                    end else if (!r_poll_phase) begin
                        r_poll_phase <= 1'b1;
                    end else if (!w_status_idle) begin
                        r_csr_read   <= 1'b1;
                        r_poll_phase <= 1'b0;
                    end else if (!avmm_csr_readdata[4] || (r_num_words == '0)) begin
                        r_error     <= ~avmm_csr_readdata[4];
                        r_csr_write <= 1'b1;
                        r_csr_addr  <= 1'b1;
                        r_csr_wdata <= CTRL_PROT;
                        r_state     <= S_PROT;
                    end else begin
                        r_pram_re   <= 1'b1;
                        r_pram_addr <= r_index;
                        r_state     <= S_RAMRD;
                    end
                end

                S_RAMRD: begin
                    r_timer <= '0;
                    r_state <= S_WR;
                end

                // First cycle captures the RAM word; then hold until the slave accepts
                S_WR: begin
                    r_timer <= r_timer + TMR_W'(1);
                    if (w_timeout) begin
                        r_error      <= 1'b1;
                        r_data_write <= 1'b0;
                        r_csr_write  <= 1'b1;
                        r_csr_addr   <= 1'b1;
                        r_csr_wdata  <= CTRL_PROT;
                        r_state      <= S_PROT;
                    end else if (!r_data_write) begin
                        r_data_write <= 1'b1;
                        r_data_addr  <= w_flash_addr;
                        r_data_wdata <= w_swapped;
                    end else if (!avmm_data_waitrequest) begin
                        r_data_write <= 1'b0;
                        r_csr_read   <= 1'b1;
                        r_csr_addr   <= 1'b0;
                        r_poll_phase <= 1'b0;
                        r_timer      <= '0;
                        r_state      <= S_WPOLL;
                    end
                end

                S_WPOLL: begin
                    r_timer <= r_timer + TMR_W'(1);
                    if (w_timeout) begin
                        r_error     <= 1'b1;
                        r_csr_write <= 1'b1;
                        r_csr_addr  <= 1'b1;
                        r_csr_wdata <= CTRL_PROT;
                        r_state     <= S_PROT;
                    end else if (!r_poll_phase) begin
                        r_poll_phase <= 1'b1;
                    end else if (!w_status_idle) begin
                        r_csr_read   <= 1'b1;
                        r_poll_phase <= 1'b0;
                    end else if (!avmm_csr_readdata[3] || w_last) begin
                        r_error     <= ~avmm_csr_readdata[3];
                        r_csr_write <= 1'b1;
                        r_csr_addr  <= 1'b1;
                        r_csr_wdata <= CTRL_PROT;
                        r_state     <= S_PROT;
                    end else begin
                        r_index     <= r_index + RAM_ADDR_WIDTH'(1);
                        r_pram_re   <= 1'b1;
                        r_pram_addr <= r_index + RAM_ADDR_WIDTH'(1);
                        r_state     <= S_RAMRD;
                    end
                end

                S_PROT: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_busy       <= 1'b0;
                    r_data_write <= 1'b0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    assign busy                 = r_busy;
    assign done                 = r_done;
    assign error                = r_error;
    assign pram_re              = r_pram_re;
    assign pram_addr            = r_pram_addr;
    assign avmm_csr_addr        = r_csr_addr;
    assign avmm_csr_read        = r_csr_read;
    assign avmm_csr_write       = r_csr_write;
    assign avmm_csr_writedata   = r_csr_wdata;
    assign avmm_data_addr       = r_data_addr;
    assign avmm_data_write      = r_data_write;
    assign avmm_data_writedata  = r_data_wdata;
    assign avmm_data_burstcount = r_burstcount;

endmodule

// File: tb/tb_code_mem_flash_programmer.sv
// tb_code_mem_flash_programmer
// Scoreboard bench: expected bus transactions are queued when a test starts and a
// monitor pops and compares each CSR write, accepted data write and done pulse.
// Small RAM and flash-status models respond to the DUT's read strobes.
module tb_code_mem_flash_programmer;

    localparam int unsigned RAW  = 4;
    localparam int unsigned FAW  = 17;
    localparam int unsigned BASE = 32'h100;
    localparam int unsigned SEC  = 3;
    localparam int unsigned TMO  = 40;

    localparam logic [31:0] C_UNPROT = 32'h0DF0_0000;
    localparam logic [31:0] C_ERASE  = 32'h0DB0_0000;
    localparam logic [31:0] C_PROT   = 32'h0FF0_0000;

    localparam logic [1:0] K_CSR  = 2'd0;
    localparam logic [1:0] K_DATA = 2'd1;
    localparam logic [1:0] K_DONE = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [RAW:0]    num_words;
    logic            busy, done, error;
    logic            pram_re;
    logic [RAW-1:0]  pram_addr;
    logic [31:0]     pram_rdata = '0;
    logic            avmm_csr_addr, avmm_csr_read, avmm_csr_write;
    logic [31:0]     avmm_csr_writedata;
    logic [31:0]     avmm_csr_readdata = '0;
    logic [FAW-1:0]  avmm_data_addr;
    logic            avmm_data_write;
    logic [31:0]     avmm_data_writedata;
    logic            avmm_data_waitrequest;
    logic [1:0]      avmm_data_burstcount;

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];

    logic [31:0] ram [16];
    logic        erase_ok = 1'b1, write_ok = 1'b1, stuck = 1'b0;
    int          poll_cnt = 0;
    logic        wr_seen = 1'b0;
    logic [FAW-1:0] stall_addr = FAW'(BASE + 2);
    int          stall_target = 0, stall_used = 0;
    logic        t2_arm = 1'b0;
    int          hold_cnt = 0, acc_cnt = 0;
    logic [31:0] hold_data = '0;
    logic        hold_bad = 1'b0;

    code_mem_flash_programmer #(
        .RAM_ADDR_WIDTH  (RAW),
        .FLASH_ADDR_WIDTH(FAW),
        .FLASH_BASE_WORD (BASE),
        .SECTOR_ID       (SEC),
        .POLL_TIMEOUT    (TMO)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .start                (start),
        .num_words            (num_words),
        .busy                 (busy),
        .done                 (done),
        .error                (error),
        .pram_re              (pram_re),
        .pram_addr            (pram_addr),
        .pram_rdata           (pram_rdata),
        .avmm_csr_addr        (avmm_csr_addr),
        .avmm_csr_read        (avmm_csr_read),
        .avmm_csr_write       (avmm_csr_write),
        .avmm_csr_writedata   (avmm_csr_writedata),
        .avmm_csr_readdata    (avmm_csr_readdata),
        .avmm_data_addr       (avmm_data_addr),
        .avmm_data_write      (avmm_data_write),
        .avmm_data_writedata  (avmm_data_writedata),
        .avmm_data_waitrequest(avmm_data_waitrequest),
        .avmm_data_burstcount (avmm_data_burstcount)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] bswap(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    // RAM model: data one cycle after the read strobe
    always @(posedge clk) if (pram_re) pram_rdata <= ram[pram_addr];

    // Flash data port stalls a chosen address for stall_target cycles
    assign avmm_data_waitrequest = avmm_data_write && (avmm_data_addr == stall_addr)
                                   && (stall_used < stall_target);
    always @(posedge clk) if (avmm_data_waitrequest) stall_used <= stall_used + 1;

    // Flash status model: busy for two reads after each command, then the ok bits
    always @(posedge clk) begin
        if (avmm_csr_read) begin
            if ((stuck && wr_seen) || poll_cnt < 2) avmm_csr_readdata <= 32'h2;
            else avmm_csr_readdata <= {27'b0, erase_ok, write_ok, 3'b000};
        end
        if (avmm_csr_write) begin
            poll_cnt <= 0;
            wr_seen  <= 1'b0;
        end else if (avmm_data_write && !avmm_data_waitrequest) begin
            poll_cnt <= 0;
            wr_seen  <= 1'b1;
        end else if (avmm_csr_read) begin
            poll_cnt <= poll_cnt + 1;
        end
    end

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic sb_check(input string name, input logic [1:0] kind,
                            input logic [31:0] addr, input logic [31:0] data);
        exp_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s: unexpected kind=%0d addr=%h data=%h, want nothing", name, kind, addr, data);
        end else begin
            e = exp_q.pop_front();
            if (e.kind !== kind || e.addr !== addr || e.data !== data) begin
                bad++;
                $display("FAIL %s: got kind=%0d addr=%h data=%h want kind=%0d addr=%h data=%h",
                         name, kind, addr, data, e.kind, e.addr, e.data);
            end
        end
    endtask

    // Monitor: compares observed transactions against the scoreboard queue
    always @(negedge clk) begin
        if (!reset) begin
            if (avmm_csr_write)
                sb_check("csr_wr", K_CSR, 32'(avmm_csr_addr), avmm_csr_writedata);
            if (avmm_data_write && !avmm_data_waitrequest)
                sb_check("data_wr", K_DATA, 32'(avmm_data_addr), avmm_data_writedata);
            if (done)
                sb_check("done", K_DONE, 32'h0, 32'(error));
            if (t2_arm && avmm_data_write && avmm_data_addr == stall_addr) begin
                if (hold_cnt == 0) hold_data <= avmm_data_writedata;
                else if (avmm_data_writedata !== hold_data) hold_bad <= 1'b1;
                hold_cnt <= hold_cnt + 1;
                if (!avmm_data_waitrequest) acc_cnt <= acc_cnt + 1;
            end
        end
    end

    task automatic push(input logic [1:0] k, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        e.kind = k; e.addr = a; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic push_four_ok();
        push(K_CSR, 32'h1, C_UNPROT);
        push(K_CSR, 32'h1, C_ERASE);
        push(K_DATA, BASE + 0, 32'h44332211);
        push(K_DATA, BASE + 1, 32'h88776655);
        push(K_DATA, BASE + 2, 32'hCCBBAA99);
        push(K_DATA, BASE + 3, 32'hEFBEADDE);
        push(K_CSR, 32'h1, C_PROT);
        push(K_DONE, 32'h0, 32'h0);
    endtask

    task automatic pulse_start(input logic [RAW:0] n);
        start = 1'b1;
        num_words = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int max);
        int n = 0;
        while (!done && n < max) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL %s: no done within %0d cycles, got busy=%b want done=1", name, max, busy);
        end
        @(negedge clk);
    endtask

    initial begin
        ram[0] = 32'h11223344;
        ram[1] = 32'h55667788;
        ram[2] = 32'h99AABBCC;
        ram[3] = 32'hDEADBEEF;
        for (int i = 4; i < 16; i++) ram[i] = 32'hA5000000 | (32'(i) << 8) | 32'(i);
        start = 1'b0;
        num_words = '0;
        reset = 1'b0;
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);

        check_eq("rst_strobes", {28'b0, busy, done, error, pram_re}, 32'h0);
        check_eq("rst_bus", {29'b0, avmm_csr_read, avmm_csr_write, avmm_data_write}, 32'h0);
        check_eq("rst_burst", 32'(avmm_data_burstcount), 32'h1);
        check_eq("rst_addr", 32'(avmm_data_addr), 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // 1: four words, no stalls
        push_four_ok();
        pulse_start(5'd4);
        check_eq("t1_busy", 32'(busy), 32'h1);
        wait_done("t1", 500);
        check_eq("t1_drain", exp_q.size(), 0);
        check_eq("t1_error", 32'(error), 32'h0);

        // 2: five stall cycles on word 2
        t2_arm = 1'b1;
        stall_target = 5;
        push_four_ok();
        pulse_start(5'd4);
        wait_done("t2", 500);
        t2_arm = 1'b0;
        check_eq("t2_drain", exp_q.size(), 0);
        check_eq("t2_hold_cycles", hold_cnt, 6);
        check_eq("t2_hold_stable", 32'(hold_bad), 32'h0);
        check_eq("t2_accepts", acc_cnt, 1);

        // 3: erase fails
        erase_ok = 1'b0;
        push(K_CSR, 32'h1, C_UNPROT);
        push(K_CSR, 32'h1, C_ERASE);
        push(K_CSR, 32'h1, C_PROT);
        push(K_DONE, 32'h0, 32'h1);
        pulse_start(5'd4);
        wait_done("t3", 500);
        check_eq("t3_drain", exp_q.size(), 0);
        check_eq("t3_error", 32'(error), 32'h1);
        erase_ok = 1'b1;

        // 4: write poll stuck busy -> timeout
        stuck = 1'b1;
        push(K_CSR, 32'h1, C_UNPROT);
        push(K_CSR, 32'h1, C_ERASE);
        push(K_DATA, BASE + 0, 32'h44332211);
        push(K_CSR, 32'h1, C_PROT);
        push(K_DONE, 32'h0, 32'h1);
        pulse_start(5'd2);
        wait_done("t4", 500);
        check_eq("t4_drain", exp_q.size(), 0);
        check_eq("t4_error", 32'(error), 32'h1);
        stuck = 1'b0;

        // 5: zero words, start while busy and in the done cycle both dropped
        push(K_CSR, 32'h1, C_UNPROT);
        push(K_CSR, 32'h1, C_ERASE);
        push(K_CSR, 32'h1, C_PROT);
        push(K_DONE, 32'h0, 32'h0);
        pulse_start(5'd0);
        @(negedge clk);
        pulse_start(5'd3);
        begin
            int n = 0;
            while (!done && n < 500) begin
                @(negedge clk);
                n++;
            end
        end
        check_eq("t5_done_seen", 32'(done), 32'h1);
        start = 1'b1;
        num_words = 5'd1;
        @(negedge clk);
        start = 1'b0;
        check_eq("t5_done_start_ignored", 32'(busy), 32'h0);
        repeat (20) @(negedge clk);
        check_eq("t5_idle", 32'(busy), 32'h0);
        check_eq("t5_drain", exp_q.size(), 0);
        check_eq("t5_error_cleared", 32'(error), 32'h0);

        // 6: reset during the data write, then a clean rerun
        push(K_CSR, 32'h1, C_UNPROT);
        push(K_CSR, 32'h1, C_ERASE);
        push(K_DATA, BASE + 0, 32'h44332211);
        pulse_start(5'd4);
        begin
            int n = 0;
            while (!avmm_data_write && n < 200) begin
                @(negedge clk);
                n++;
            end
        end
        check_eq("t6_in_wr", 32'(avmm_data_write), 32'h1);
        #1 reset = 1'b1;
        check_eq("t6_drain", exp_q.size(), 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        check_eq("t6_rst_strobes", {28'b0, busy, done, error, pram_re}, 32'h0);
        check_eq("t6_rst_bus", {29'b0, avmm_csr_read, avmm_csr_write, avmm_data_write}, 32'h0);
        check_eq("t6_rst_wdata", avmm_data_writedata, 32'h0);
        check_eq("t6_rst_burst", 32'(avmm_data_burstcount), 32'h1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        push_four_ok();
        pulse_start(5'd4);
        wait_done("t6_rerun", 500);
        check_eq("t6_rerun_drain", exp_q.size(), 0);

        // 7: word count above RAM size is clamped to 16
        push(K_CSR, 32'h1, C_UNPROT);
        push(K_CSR, 32'h1, C_ERASE);
        for (int i = 0; i < 16; i++) push(K_DATA, BASE + 32'(i), bswap(ram[i]));
        push(K_CSR, 32'h1, C_PROT);
        push(K_DONE, 32'h0, 32'h0);
        pulse_start(5'd20);
        wait_done("t7", 2000);
        check_eq("t7_drain", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
